msrv32_ahb_mem_responder: RTL and testbench
===========================================

# msrv32_ahb_mem_responder

Parametrised, synthesisable dual-port memory responder for the msrv32 core's instruction and data buses, replacing ad-hoc stimulus of `instr_in`/`data_in`/`hready`/`hresp` in core-level benches. It serves instruction fetches and AHB-lite data transfers from one shared word array. Wait states are runtime-programmable per port. It returns two-cycle AHB ERROR responses for illegal data accesses, and it is preloadable through a side port. It sits directly opposite `msrv32_top` in simulation and FPGA bring-up.

## Interface
- `DEPTH_WORDS`, 1024: memory size in 32-bit words; must be a power of two.
- `WAIT_W`, 4: width of the wait-state configuration inputs.
- `NOP_WORD`, 32'h0000_0013: word returned for out-of-range fetches and driven on `instr_out` at reset.
- `ms_riscv32_mp_clk_in`  in  1  single clock; all state updates on the rising edge.
- `ms_riscv32_mp_rst_n_in`  in  1  reset, asynchronous assert, active-low.
- `imaddr_in`  in  32  instruction fetch address from core.
- `instr_out`  out  32  fetched instruction.
- `instr_hready_out`  out  1  instruction port ready / data valid.
- `iwait_in`  in  WAIT_W  instruction wait states per fetch.
- `dmaddr_in`  in  32  data address, address phase.
- `data_htrans_in`  in  2  AHB transfer type; only 2'b10 (NONSEQ) starts a transfer.
- `dmwr_req_in`  in  1  1 = write, 0 = read; sampled in the address phase.
- `dmwr_mask_in`  in  4  byte-lane enables; sampled in the address phase.
- `dmdata_in`  in  32  write data, sampled on the final data-phase edge.
- `data_out`  out  32  read data.
- `data_hready_out`  out  1  AHB HREADY.
- `hresp_out`  out  1  AHB HRESP (1 = ERROR).
- `dwait_in`  in  WAIT_W  data wait states per transfer.
- `ld_en_in`  in  1  preload write strobe.
- `ld_addr_in`  in  $clog2(DEPTH_WORDS)  preload word index.
- `ld_data_in`  in  32  preload data.

## Operation
- Word index = `addr[$clog2(DEPTH_WORDS)+1:2]`. In range means `addr[31:2] < DEPTH_WORDS`.
- Instruction port FSM has states I_READY and I_WAIT.
  - I_READY: at each edge with `instr_hready_out`=1, sample `imaddr_in` and load the counter with `iwait_in`.
  - If `iwait_in`=0, stay in I_READY and register `instr_out` = mem[idx], or `NOP_WORD` if out of range.
  - Otherwise go to I_WAIT with hready low.
  - I_WAIT: decrement the counter each edge. When it reaches 0, load `instr_out`, raise hready and return to I_READY.
- Data port FSM has states D_IDLE, D_WAIT, D_ERR1 and D_ERR2.
  - Accept an address phase when `data_htrans_in`=2'b10 and `data_hready_out`=1. Latch addr, wr, mask and the counter (`dwait_in`).
  - Error condition: `addr[1:0]`≠0 or out of range. Go to D_ERR1 with hready=0, hresp=1, then D_ERR2 with hready=1, hresp=1, then D_IDLE. Memory is untouched and `data_out` holds its value.
  - Legal transfer: stay in D_WAIT with hready=0 while the counter is >0, decrementing each edge.
  - On the completing edge (counter=0), a write applies `dmdata_in` to the enabled byte lanes. A read loads `data_out` = mem[idx].
  - A new NONSEQ accepted on the completing edge starts its own data phase immediately (pipelined). Otherwise go to D_IDLE.
- Forwarding: when a read completes on the same edge a write to the same word completes, `data_out` returns the merged (post-write) word.
- Preload: `ld_en_in` writes `ld_data_in` to mem[`ld_addr_in`] with all lanes enabled. It has priority over a data-port write to the same word on the same edge.
- Memory contents are not reset.

## Timing
- Reset values: `instr_out`=`NOP_WORD`, `instr_hready_out`=1, `data_out`=0, `data_hready_out`=1, `hresp_out`=0. Both FSMs go to their idle states and the counters clear.
- Asserting reset mid-transfer aborts it. A pending write is not applied.
- Instruction latency is 1 + `iwait_in` cycles from the sampling edge to valid `instr_out` with hready=1.
- Data read latency is 1 + `dwait_in` cycles from the address-phase edge to `data_out` valid with hready=1.
- `iwait_in`/`dwait_in` are sampled only at acceptance. Changing them mid-wait has no effect on the current transfer.
- `data_htrans_in` of IDLE (2'b00) or BUSY (2'b01) gives a zero-wait OKAY response (hready=1, hresp=0) and no memory access. SEQ (2'b11) is treated as NONSEQ.
- An ERROR response always takes exactly 2 cycles, independent of `dwait_in`.
- A maximum wait of 2^WAIT_W−1 cycles must not wrap the counter.

## Test plan
- Reset: pulse rst_n low during a data wait state → within the same cycle `data_hready_out`=1, `hresp_out`=0, `instr_out`=0x00000013. After release, the aborted write word keeps its old value.
- Fetch: preload mem[0]=0x00500093, `iwait_in`=0, `imaddr_in`=0 → `instr_out`=0x00500093 with hready=1 one cycle after sampling. With `iwait_in`=3 → hready low for 3 cycles, then data.
- Read with wait: mem[4]=0xDEADBEEF, `dwait_in`=2, NONSEQ read of 0x10 → `data_hready_out` low for 2 cycles, then high with `data_out`=0xDEADBEEF.
- Masked write: mem[8]=0xAAAAAAAA, write 0x11223344 with mask 4'b0101 to 0x20 → readback 0xAA22AA44.
- Error: NONSEQ to 0x1002 → cycle 1 hready=0/hresp=1, cycle 2 hready=1/hresp=1. The same sequence occurs for address 0x0001_0000 with DEPTH_WORDS=1024. Memory is unchanged.
- Pipelined RAW: `dwait_in`=0, write 0x0000CAFE to 0x40, then read 0x40 accepted on the write's completing edge → `data_out`=0x0000CAFE (forwarded). A simultaneous `ld_en_in` to word 16 with 0x12345678 → readback 0x12345678.

Source files
------------

// File: rtl/msrv32_ahb_mem_responder.sv
// Purpose: shared-word memory that serves msrv32 instruction fetches and AHB-lite data transfers, with side-port preload.
// Latency: fetch 1+iwait_in cycles from sampling edge; data read 1+dwait_in cycles from address phase; ERROR always 2 cycles.
// Backpressure: each port holds its hready low for the programmed wait states; a data phase accepts the next NONSEQ on its final edge.
//
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_n_in : clock, async active-low reset
//   imaddr_in, iwait_in -> instr_out, instr_hready_out : instruction fetch port
//   dmaddr_in, data_htrans_in, dmwr_req_in, dmwr_mask_in, dmdata_in, dwait_in
//     -> data_out, data_hready_out, hresp_out           : AHB-lite data port
//   ld_en_in, ld_addr_in, ld_data_in                    : preload side port (wins over data writes)
module msrv32_ahb_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_W      = 4,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                           ms_riscv32_mp_clk_in,
  input  logic                           ms_riscv32_mp_rst_n_in,
  input  logic [31:0]                    imaddr_in,
  output logic [31:0]                    instr_out,
  output logic                           instr_hready_out,
  input  logic [WAIT_W-1:0]              iwait_in,
  input  logic [31:0]                    dmaddr_in,
  input  logic [1:0]                     data_htrans_in,
  input  logic                           dmwr_req_in,
  input  logic [3:0]                     dmwr_mask_in,
  input  logic [31:0]                    dmdata_in,
  output logic [31:0]                    data_out,
  output logic                           data_hready_out,
  output logic                           hresp_out,
  input  logic [WAIT_W-1:0]              dwait_in,
  input  logic                           ld_en_in,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr_in,
  input  logic [31:0]                    ld_data_in
);

  localparam int AW = $clog2(DEPTH_WORDS);
  typedef logic [AW-1:0] idx_t;

  typedef enum logic {I_READY, I_WAIT} i_state_t;
  // D_WAIT covers the whole legal data phase: wait cycles (r_dcnt>0) and
  // the final hready=1 cycle (r_dcnt==0), whose closing edge completes it.
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_ERR1, D_ERR2} d_state_t;

  function automatic logic in_range(input logic [29:0] waddr);
    return waddr < 30'(DEPTH_WORDS);
  endfunction

  logic [31:0] r_mem [DEPTH_WORDS];

  // ---------------- instruction port ----------------
  i_state_t          r_istate;
  logic [WAIT_W-1:0] r_icnt;
  idx_t              r_iidx;
  logic              r_iinr;
  logic [31:0]       r_instr;
  logic              r_ihready;

  logic [31:0] w_fetch_now;
  logic [31:0] w_fetch_held;
  logic        w_unused;

  assign w_fetch_now  = in_range(imaddr_in[31:2]) ? r_mem[imaddr_in[AW+1:2]] : NOP_WORD;
  assign w_fetch_held = r_iinr ? r_mem[r_iidx] : NOP_WORD;
  // Byte offset of a fetch address is irrelevant: fetches are whole words.
  assign w_unused     = &{1'b0, imaddr_in[1:0]};

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      r_istate  <= I_READY;
      r_icnt    <= '0;
      r_iidx    <= '0;
      r_iinr    <= 1'b0;
      r_instr   <= NOP_WORD;
      r_ihready <= 1'b1;
    end else begin
      case (r_istate)
        I_READY: begin
          r_iidx <= imaddr_in[AW+1:2];
          r_iinr <= in_range(imaddr_in[31:2]);
          r_icnt <= iwait_in;
          if (iwait_in == '0) begin
            r_instr <= w_fetch_now;
          end else begin
            r_istate  <= I_WAIT;
            r_ihready <= 1'b0;
          end
        end
        default: begin
          r_icnt <= r_icnt - 1'b1;
          // Counter reaching zero on this edge makes the fetched word visible.
          if (r_icnt == WAIT_W'(1)) begin
            r_instr   <= w_fetch_held;
            r_ihready <= 1'b1;
            r_istate  <= I_READY;
          end
        end
      endcase
    end
  end

  assign instr_out        = r_instr;
  assign instr_hready_out = r_ihready;

  // ---------------- data port ----------------
  d_state_t          r_dstate;
  logic [WAIT_W-1:0] r_dcnt;
  idx_t              r_didx;
  logic              r_dwr;
  logic [3:0]        r_dmask;
  logic [31:0]       r_data;
  logic              r_dhready;
  logic              r_hresp;

  logic        w_acc;
  logic        w_new_err;
  idx_t        w_new_idx;
  logic        w_in_wait;
  logic        w_wr_fire;
  idx_t        w_rd_idx;
  logic [31:0] w_wr_word;
  logic [31:0] w_rd_word;

  // SEQ is treated as NONSEQ, so only bit 1 of htrans matters.
  assign w_acc     = data_htrans_in[1] & r_dhready;
  assign w_new_err = (dmaddr_in[1:0] != 2'b00) | ~in_range(dmaddr_in[31:2]);
  assign w_new_idx = dmaddr_in[AW+1:2];
  assign w_in_wait = (r_dstate == D_WAIT) && (r_dcnt != '0);
  assign w_wr_fire = (r_dstate == D_WAIT) && (r_dcnt == '0) && r_dwr;
  // A read loads data_out either on its last wait edge or, with no wait,
  // on its own address-phase edge.
  assign w_rd_idx  = w_in_wait ? r_didx : w_new_idx;

  always_comb begin
    w_wr_word = r_mem[r_didx];
    for (int b = 0; b < 4; b++) begin
      if (r_dmask[b]) w_wr_word[8*b +: 8] = dmdata_in[8*b +: 8];
    end
  end

  // Read data is the word as it stands after this edge's writes, so a read
  // pipelined behind a write to the same word sees the merged value, and a
  // concurrent preload overrides both.
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    if (w_wr_fire && (r_didx == w_rd_idx)) w_rd_word = w_wr_word;
    if (ld_en_in && (ld_addr_in == w_rd_idx)) w_rd_word = ld_data_in;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      r_dstate  <= D_IDLE;
      r_dcnt    <= '0;
      r_didx    <= '0;
      r_dwr     <= 1'b0;
      r_dmask   <= '0;
      r_data    <= '0;
      r_dhready <= 1'b1;
      r_hresp   <= 1'b0;
    end else if (r_dstate == D_ERR1) begin
      r_dstate  <= D_ERR2;
      r_dhready <= 1'b1;
      r_hresp   <= 1'b1;
    end else if (w_in_wait) begin
      r_dcnt <= r_dcnt - 1'b1;
      if (r_dcnt == WAIT_W'(1)) begin
        r_dhready <= 1'b1;
        if (!r_dwr) r_data <= w_rd_word;
      end
    end else begin
      // D_IDLE, D_ERR2 or the final data-phase cycle: hready is high, so a
      // new address phase may be accepted here.
      r_hresp   <= 1'b0;
      r_dhready <= 1'b1;
      r_dstate  <= D_IDLE;
      if (w_acc) begin
        r_didx  <= w_new_idx;
        r_dwr   <= dmwr_req_in;
        r_dmask <= dmwr_mask_in;
        if (w_new_err) begin
          r_dstate  <= D_ERR1;
          r_dcnt    <= '0;
          r_dhready <= 1'b0;
          r_hresp   <= 1'b1;
        end else begin
          r_dstate <= D_WAIT;
          r_dcnt   <= dwait_in;
          if (dwait_in == '0) begin
            if (!dmwr_req_in) r_data <= w_rd_word;
          end else begin
            r_dhready <= 1'b0;
          end
        end
      end
    end
  end

  // Memory is not reset; preload is written last so it wins on a clash.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (w_wr_fire) r_mem[r_didx] <= w_wr_word;
    if (ld_en_in)  r_mem[ld_addr_in] <= ld_data_in;
  end

  assign data_out        = r_data;
  assign data_hready_out = r_dhready;
  assign hresp_out       = r_hresp;

endmodule

// File: tb/tb_msrv32_ahb_mem_responder.sv
// Bench for msrv32_ahb_mem_responder: directed stimulus, a cycle-schedule
// reference model compared every cycle, and literal expectations.
module tb_msrv32_ahb_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imaddr_in = '0;
  logic [31:0] instr_out;
  logic        instr_hready_out;
  logic [3:0]  iwait_in = '0;
  logic [31:0] dmaddr_in = '0;
  logic [1:0]  data_htrans_in = '0;
  logic        dmwr_req_in = 1'b0;
  logic [3:0]  dmwr_mask_in = '0;
  logic [31:0] dmdata_in = '0;
  logic [31:0] data_out;
  logic        data_hready_out;
  logic        hresp_out;
  logic [3:0]  dwait_in = '0;
  logic        ld_en_in = 1'b0;
  logic [9:0]  ld_addr_in = '0;
  logic [31:0] ld_data_in = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  msrv32_ahb_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_W(4), .NOP_WORD(NOP)) dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_n_in(rst_n),
    .imaddr_in             (imaddr_in),
    .instr_out             (instr_out),
    .instr_hready_out      (instr_hready_out),
    .iwait_in              (iwait_in),
    .dmaddr_in             (dmaddr_in),
    .data_htrans_in        (data_htrans_in),
    .dmwr_req_in           (dmwr_req_in),
    .dmwr_mask_in          (dmwr_mask_in),
    .dmdata_in             (dmdata_in),
    .data_out              (data_out),
    .data_hready_out       (data_hready_out),
    .hresp_out             (hresp_out),
    .dwait_in              (dwait_in),
    .ld_en_in              (ld_en_in),
    .ld_addr_in            (ld_addr_in),
    .ld_data_in            (ld_data_in)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each port is a queue of upcoming cycles: an accepted request schedules
  // its wait cycles and its final cycle; an empty queue means idle/ready.
  typedef struct {
    logic       rdy;
    logic       rsp;
    logic       rd;
    logic       wr;
    int         idx;
    logic [3:0] mask;
  } dcyc_t;
  typedef struct {
    logic rdy;
    logic inr;
    int   idx;
  } icyc_t;

  logic [31:0] mmem [DEPTH];
  dcyc_t dq[$];
  icyc_t iq[$];
  logic        e_irdy, e_drdy, e_rsp;
  logic [31:0] e_instr, e_dout;
  logic        cur_wr;
  int          cur_idx;
  logic [3:0]  cur_mask;
  logic        m_init = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = 'x;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq.delete();
      iq.delete();
      e_irdy = 1'b1; e_instr = NOP;
      e_drdy = 1'b1; e_rsp = 1'b0; e_dout = '0;
      cur_wr = 1'b0; cur_idx = 0; cur_mask = '0;
      m_init = 1'b1;
    end else begin
      icyc_t ic;
      dcyc_t dc;
      // instruction port: fetch sees memory before this edge's writes
      if (e_irdy) begin
        for (int i = 0; i < int'(iwait_in); i++) iq.push_back('{rdy:1'b0, inr:1'b0, idx:0});
        iq.push_back('{rdy:1'b1, inr:(imaddr_in[31:2] < 30'(DEPTH)), idx:int'(imaddr_in[11:2])});
      end
      if (iq.size() > 0) begin
        ic = iq.pop_front();
        e_irdy = ic.rdy;
        if (ic.rdy) e_instr = ic.inr ? mmem[ic.idx] : NOP;
      end
      // writes closing on this edge, preload last
      if (cur_wr) begin
        for (int b = 0; b < 4; b++)
          if (cur_mask[b]) mmem[cur_idx][8*b +: 8] = dmdata_in[8*b +: 8];
      end
      if (ld_en_in) mmem[int'(ld_addr_in)] = ld_data_in;
      // data address phase
      if (e_drdy && data_htrans_in[1]) begin
        if (dmaddr_in[1:0] != 2'b00 || dmaddr_in[31:2] >= 30'(DEPTH)) begin
          dq.push_back('{rdy:1'b0, rsp:1'b1, rd:1'b0, wr:1'b0, idx:0, mask:4'h0});
          dq.push_back('{rdy:1'b1, rsp:1'b1, rd:1'b0, wr:1'b0, idx:0, mask:4'h0});
        end else begin
          for (int i = 0; i < int'(dwait_in); i++)
            dq.push_back('{rdy:1'b0, rsp:1'b0, rd:1'b0, wr:1'b0, idx:0, mask:4'h0});
          dq.push_back('{rdy:1'b1, rsp:1'b0, rd:!dmwr_req_in, wr:dmwr_req_in,
                         idx:int'(dmaddr_in[11:2]), mask:dmwr_mask_in});
        end
      end
      if (dq.size() > 0) dc = dq.pop_front();
      else dc = '{rdy:1'b1, rsp:1'b0, rd:1'b0, wr:1'b0, idx:0, mask:4'h0};
      e_drdy = dc.rdy;
      e_rsp  = dc.rsp;
      if (dc.rd) e_dout = mmem[dc.idx];
      cur_wr = dc.wr; cur_idx = dc.idx; cur_mask = dc.mask;
    end
  end

  task automatic chkm(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (!$isunknown(exp)) chk(nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      chkm("m_instr_hready", 32'(instr_hready_out), 32'(e_irdy));
      chkm("m_instr_out", instr_out, e_instr);
      chkm("m_data_hready", 32'(data_hready_out), 32'(e_drdy));
      chkm("m_hresp", 32'(hresp_out), 32'(e_rsp));
      chkm("m_data_out", data_out, e_dout);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic ld(input int idx, input logic [31:0] d);
    ld_en_in = 1'b1; ld_addr_in = 10'(idx); ld_data_in = d;
    cyc();
    ld_en_in = 1'b0;
  endtask

  task automatic fetch_lit(input logic [31:0] a, input int iw, input logic [31:0] exp, input string nm);
    int n;
    imaddr_in = a; iwait_in = 4'(iw);
    cyc();
    iwait_in = 4'd0;   // mid-wait change must not alter this fetch
    n = 0;
    while (!instr_hready_out && n < 40) begin n++; cyc(); end
    chk({nm, "_wait"}, 32'(n), 32'(iw));
    chk({nm, "_data"}, instr_out, exp);
  endtask

  task automatic read_lit(input logic [31:0] a, input int dw, input logic [31:0] exp, input string nm);
    int n;
    data_htrans_in = 2'b10; dmaddr_in = a; dmwr_req_in = 1'b0; dwait_in = 4'(dw);
    cyc();
    data_htrans_in = 2'b00; dwait_in = 4'd0;
    n = 0;
    while (!data_hready_out && n < 40) begin n++; cyc(); end
    chk({nm, "_wait"}, 32'(n), 32'(dw));
    chk({nm, "_data"}, data_out, exp);
    cyc();
  endtask

  task automatic write_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input int dw);
    int n;
    data_htrans_in = 2'b10; dmaddr_in = a; dmwr_req_in = 1'b1; dmwr_mask_in = m;
    dmdata_in = d; dwait_in = 4'(dw);
    cyc();
    data_htrans_in = 2'b00; dwait_in = 4'd0;
    n = 0;
    while (!data_hready_out && n < 40) begin n++; cyc(); end
    chk("wr_wait", 32'(n), 32'(dw));
    cyc();
    dmwr_req_in = 1'b0;
  endtask

  task automatic err_lit(input logic [31:0] a, input string nm);
    data_htrans_in = 2'b10; dmaddr_in = a; dmwr_req_in = 1'b1; dmwr_mask_in = 4'hF;
    dmdata_in = 32'hFFFF_FFFF; dwait_in = 4'd7;
    cyc();
    data_htrans_in = 2'b00; dmwr_req_in = 1'b0; dwait_in = 4'd0;
    chk({nm, "_c1_hready"}, 32'(data_hready_out), 32'd0);
    chk({nm, "_c1_hresp"}, 32'(hresp_out), 32'd1);
    cyc();
    chk({nm, "_c2_hready"}, 32'(data_hready_out), 32'd1);
    chk({nm, "_c2_hresp"}, 32'(hresp_out), 32'd1);
    cyc();
    chk({nm, "_c3_hready"}, 32'(data_hready_out), 32'd1);
    chk({nm, "_c3_hresp"}, 32'(hresp_out), 32'd0);
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_instr_out", instr_out, NOP);
    chk("rst_instr_hready", 32'(instr_hready_out), 32'd1);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_data_hready", 32'(data_hready_out), 32'd1);
    chk("rst_hresp", 32'(hresp_out), 32'd0);
    rst_n = 1'b1;
    cyc();

    // instruction fetches
    ld(0, 32'h0050_0093);
    ld(1, 32'h00a0_0113);
    fetch_lit(32'h0, 0, 32'h0050_0093, "fetch_w0");
    fetch_lit(32'h4, 3, 32'h00a0_0113, "fetch_w3");
    fetch_lit(32'h0001_0000, 0, NOP, "fetch_oor");
    fetch_lit(32'h0, 15, 32'h0050_0093, "fetch_w15");

    // reads with various waits
    ld(4, 32'hDEAD_BEEF);
    read_lit(32'h10, 2, 32'hDEAD_BEEF, "rd_w2");
    read_lit(32'h10, 0, 32'hDEAD_BEEF, "rd_w0");
    read_lit(32'h10, 15, 32'hDEAD_BEEF, "rd_w15");

    // masked write
    ld(8, 32'hAAAA_AAAA);
    write_op(32'h20, 32'h1122_3344, 4'b0101, 1);
    read_lit(32'h20, 0, 32'hAA22_AA44, "mask_rb");

    // BUSY to an illegal address: zero-wait OKAY
    data_htrans_in = 2'b01; dmaddr_in = 32'h1002;
    cyc();
    chk("busy_hready", 32'(data_hready_out), 32'd1);
    chk("busy_hresp", 32'(hresp_out), 32'd0);
    data_htrans_in = 2'b00;
    cyc();

    // ERROR responses; both alias word 0, which must survive
    err_lit(32'h0000_1002, "err_misal");
    err_lit(32'h0001_0000, "err_oor");
    read_lit(32'h0, 0, 32'h0050_0093, "err_mem0");

    // pipelined read-after-write with forwarding
    dwait_in = 4'd0;
    data_htrans_in = 2'b10; dmaddr_in = 32'h40; dmwr_req_in = 1'b1; dmwr_mask_in = 4'hF;
    dmdata_in = 32'h0000_CAFE;
    cyc();
    dmwr_req_in = 1'b0;
    cyc();
    data_htrans_in = 2'b00;
    chk("raw_fwd", data_out, 32'h0000_CAFE);
    chk("raw_hready", 32'(data_hready_out), 32'd1);
    cyc();
    // same, with a preload to word 16 on the completing edge
    data_htrans_in = 2'b10; dmwr_req_in = 1'b1; dmdata_in = 32'h0000_F00D;
    cyc();
    dmwr_req_in = 1'b0; ld_en_in = 1'b1; ld_addr_in = 10'd16; ld_data_in = 32'h1234_5678;
    cyc();
    ld_en_in = 1'b0; data_htrans_in = 2'b00;
    chk("raw_ld_fwd", data_out, 32'h1234_5678);
    cyc();
    read_lit(32'h40, 0, 32'h1234_5678, "ld_prio_rb");

    // reset during a write's wait state
    ld(32, 32'h5555_5555);
    data_htrans_in = 2'b10; dmaddr_in = 32'h80; dmwr_req_in = 1'b1; dmwr_mask_in = 4'hF;
    dmdata_in = 32'h6666_6666; dwait_in = 4'd5;
    cyc();
    data_htrans_in = 2'b00; dwait_in = 4'd0;
    cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_hready", 32'(data_hready_out), 32'd1);
    chk("abort_hresp", 32'(hresp_out), 32'd0);
    chk("abort_instr", instr_out, NOP);
    chk("abort_data_out", data_out, 32'h0);
    cyc();
    rst_n = 1'b1; dmwr_req_in = 1'b0;
    cyc();
    read_lit(32'h80, 0, 32'h5555_5555, "abort_rb");

    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
